// File: rtl/serial_io_pkg.sv
// serial_io_pkg: shared types and helpers for the serial I/O engine.
// Holds the frame FSM state type, width helpers and default derived sizes.
package serial_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DONE
  } state_e;

  // bits needed to hold values 0..v-1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // counter width, never narrower than one bit
  function automatic int cnt_w(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DEF_OUT_W = 16;
  localparam int DEF_IN_W  = 8;
  localparam int N_BITS    = max2(DEF_OUT_W, DEF_IN_W);
  localparam int BIT_CNT_W = cnt_w(N_BITS);

endpackage

// File: rtl/serial_io_engine_debouncer.sv
// io_debouncer: per-bit frame-count debounce with rise/fall pulses.
// Ports: clk, rst_n, en (frame strobe), raw -> data, rise, fall.
module io_debouncer
  import serial_io_pkg::*;
#(
  parameter int W        = 8,
  parameter int DEBOUNCE = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] raw,
  output logic [W-1:0] data,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  localparam int CW = cnt_w(DEBOUNCE);
  localparam logic [CW-1:0] LIM = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt_q [W];
  logic [CW-1:0] cnt_d [W];
  logic [W-1:0]  data_q, data_d;
  logic [W-1:0]  rise_q, rise_d;
  logic [W-1:0]  fall_q, fall_d;

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    rise_d = '0;
    fall_d = '0;
    if (en) begin
      for (int i = 0; i < W; i++) begin
        if (raw[i] != data_q[i]) begin
          // the frame that would reach DEBOUNCE accepts the change
          if (cnt_q[i] == LIM) begin
            data_d[i] = raw[i];
            cnt_d[i]  = '0;
            rise_d[i] = raw[i];
            fall_d[i] = ~raw[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W; i++) cnt_q[i] <= '0;
      data_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign data = data_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/serial_io_engine.sv
// serial_io_engine: one-frame-at-a-time driver for a 595 output chain
// and a 165 input chain on a shared sclk, with debounced inputs.
// Ports: clk, reset (async, low), en, out_data -> sclk, sdo, out_latch,
// in_latch; sdi -> in_data, in_rise, in_fall; frame_done, busy.
module serial_io_engine
  import serial_io_pkg::*;
#(
  parameter int OUT_W    = 16,
  parameter int IN_W     = 8,
  parameter int DIV      = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [OUT_W-1:0] out_data,
  output logic             sclk,
  output logic             sdo,
  output logic             out_latch,
  output logic             in_latch,
  input  logic             sdi,
  output logic [IN_W-1:0]  in_data,
  output logic [IN_W-1:0]  in_rise,
  output logic [IN_W-1:0]  in_fall,
  output logic             frame_done,
  output logic             busy
);

  localparam int N  = max2(OUT_W, IN_W);
  localparam int BW = cnt_w(N);
  localparam int DW = cnt_w(2 * DIV);

  localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_C  = DW'(DIV);
  localparam logic [DW-1:0] PER_M1 = DW'(2 * DIV - 1);
  localparam logic [BW-1:0] LAST_B = BW'(N - 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [N-1:0]    sr_q, sr_d;
  logic [IN_W-1:0] raw_q, raw_d;
  logic            sdo_q, sdo_d;
  logic            sclk_q, sclk_d;
  logic            olat_q, olat_d;
  logic            ilat_q, ilat_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    raw_d   = raw_q;
    sdo_d   = sdo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_LOAD;
          div_d   = '0;
          // zero-extension gives the leading pad bits
          sr_d    = N'(out_data);
        end
      end
      ST_LOAD: begin
        if (div_q == DIV_M1) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          bit_d   = '0;
          sdo_d   = sr_q[N-1];
          sr_d    = sr_q << 1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_SHIFT: begin
        // capture sdi on the cycle whose edge raises sclk
        if (div_q == DIV_M1 && int'(bit_q) < IN_W)
          raw_d = (raw_q << 1) | IN_W'(sdi);
        if (div_q == PER_M1) begin
          div_d = '0;
          if (bit_q == LAST_B) begin
            state_d = ST_LATCH;
          end else begin
            bit_d = bit_q + BW'(1);
            sdo_d = sr_q[N-1];
            sr_d  = sr_q << 1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_LATCH: begin
        if (div_q == DIV_M1) begin
          state_d = ST_DONE;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_DONE: begin
        if (en) begin
          state_d = ST_LOAD;
          div_d   = '0;
          sr_d    = N'(out_data);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // pins are registered copies of the next-state decode
    sclk_d = (state_d == ST_SHIFT) && (div_d >= DIV_C);
    olat_d = (state_d == ST_LATCH);
    ilat_d = (state_d != ST_LOAD);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      raw_q   <= '0;
      sdo_q   <= 1'b0;
      sclk_q  <= 1'b0;
      olat_q  <= 1'b0;
      ilat_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      raw_q   <= raw_d;
      sdo_q   <= sdo_d;
      sclk_q  <= sclk_d;
      olat_q  <= olat_d;
      ilat_q  <= ilat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  io_debouncer #(
    .W       (IN_W),
    .DEBOUNCE(DEBOUNCE)
  ) u_deb (
    .clk  (clk),
    .rst_n(reset),
    .en   (state_q == ST_DONE),
    .raw  (raw_q),
    .data (in_data),
    .rise (in_rise),
    .fall (in_fall)
  );

  assign sclk       = sclk_q;
  assign sdo        = sdo_q;
  assign out_latch  = olat_q;
  assign in_latch   = ilat_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_serial_io_engine.sv
// tb_serial_io_engine: board-level bench with 595/165 chain models
// and a frame-level debounce reference model.
module tb_serial_io_engine;

  localparam int OUT_W  = 16;
  localparam int IN_W   = 8;
  localparam int DIV    = 4;
  localparam int DEB    = 3;
  localparam int PERIOD = DIV * (2 * 16 + 2) + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] out_data;
  logic        sclk, sdo, out_latch, in_latch, sdi;
  logic [7:0]  in_data, in_rise, in_fall;
  logic        frame_done, busy;

  always #5 clk = ~clk;

  serial_io_engine #(
    .OUT_W   (OUT_W),
    .IN_W    (IN_W),
    .DIV     (DIV),
    .DEBOUNCE(DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .out_data  (out_data),
    .sclk      (sclk),
    .sdo       (sdo),
    .out_latch (out_latch),
    .in_latch  (in_latch),
    .sdi       (sdi),
    .in_data   (in_data),
    .in_rise   (in_rise),
    .in_fall   (in_fall),
    .frame_done(frame_done),
    .busy      (busy)
  );

  // 74HC165: async parallel load while PL low, shift on sclk rise
  logic [7:0] dip = '0;
  logic [7:0] sr165 = '0;
  always @(posedge sclk or negedge in_latch)
    if (!in_latch) sr165 <= dip;
    else sr165 <= {sr165[6:0], 1'b0};
  assign sdi = sr165[7];

  // 74HC595: shift on sclk rise, storage on latch rise
  logic [15:0] sr595 = '0;
  logic [15:0] q595 = '0;
  always @(posedge sclk) sr595 <= {sr595[14:0], sdo};
  always @(posedge out_latch) q595 <= sr595;

  // per-frame pin monitor
  int          cyc = 0, last_done = 0, period_f = 0;
  int          rises_acc = 0, rises_f = 0;
  int          latch_acc = 0, latch_f = 0;
  logic [15:0] sdo_acc = '0, sdo_f = '0;
  logic        sclk_p = 1'b0;
  always @(negedge clk) begin
    cyc    <= cyc + 1;
    sclk_p <= sclk;
    if (!reset) begin
      rises_acc <= 0;
      latch_acc <= 0;
      last_done <= cyc;
    end else if (frame_done) begin
      period_f  <= cyc - last_done;
      last_done <= cyc;
      rises_f   <= rises_acc;
      latch_f   <= latch_acc;
      sdo_f     <= sdo_acc;
      rises_acc <= 0;
      latch_acc <= 0;
    end else begin
      if (sclk && !sclk_p) begin
        rises_acc <= rises_acc + 1;
        sdo_acc   <= {sdo_acc[14:0], sdo};
      end
      if (out_latch) latch_acc <= latch_acc + 1;
    end
  end

  int total = 0;
  int bad = 0;

  // debounce reference: one update per completed frame
  logic [7:0] m_data, m_rise, m_fall;
  int         m_cnt [8];

  task automatic model_reset();
    m_data = '0;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endtask

  task automatic model_apply(input logic [7:0] raw);
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < 8; i++) begin
      if (raw[i] == m_data[i]) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] + 1 >= DEB) begin
        m_data[i] = raw[i];
        m_cnt[i]  = 0;
        if (raw[i]) m_rise[i] = 1'b1;
        else m_fall[i] = 1'b1;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  task automatic do_reset();
    en = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < PERIOD * 3; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL frame_done_timeout: got none, required one");
    end
  endtask

  // cur: dip value seen by this frame; nxt: value for the next
  task automatic frame_step(input logic [7:0] cur,
                            input logic [7:0] nxt);
    bit ok;
    wait_done(ok);
    dip = nxt;
    model_apply(cur);
    @(negedge clk);
    total++;
    if (in_data !== m_data) begin
      bad++;
      $display("FAIL in_data: got %h required %h", in_data, m_data);
    end
    total++;
    if (in_rise !== m_rise) begin
      bad++;
      $display("FAIL in_rise: got %h required %h", in_rise, m_rise);
    end
    total++;
    if (in_fall !== m_fall) begin
      bad++;
      $display("FAIL in_fall: got %h required %h", in_fall, m_fall);
    end
    @(negedge clk);
    total++;
    if ({in_rise, in_fall} !== 16'h0) begin
      bad++;
      $display("FAIL edge_width: got %h/%h required 00/00",
               in_rise, in_fall);
    end
  endtask

  function automatic logic [29:0] pins();
    return {sclk, sdo, out_latch, in_latch, in_data,
            in_rise, in_fall, frame_done, busy};
  endfunction

  localparam logic [29:0] RST_PINS = {4'b0001, 24'h0, 2'b00};

  task automatic test_reset();
    out_data = '0;
    dip = '0;
    en = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (pins() !== RST_PINS) begin
      bad++;
      $display("FAIL reset_pins: got %h required %h", pins(), RST_PINS);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_frame_basic();
    do_reset();
    out_data = 16'hA5C3;
    dip = 8'h5A;
    en = 1'b1;
    for (int f = 1; f <= 4; f++) begin
      frame_step(8'h5A, 8'h5A);
      total++;
      if (sdo_f !== 16'hA5C3) begin
        bad++;
        $display("FAIL sdo_bits: got %h required a5c3", sdo_f);
      end
      total++;
      if (q595 !== 16'hA5C3) begin
        bad++;
        $display("FAIL chain595: got %h required a5c3", q595);
      end
      total++;
      if (rises_f != 16 || latch_f != 4) begin
        bad++;
        $display("FAIL frame_shape: rises %0d latch %0d required 16 4",
                 rises_f, latch_f);
      end
      if (f >= 2) begin
        total++;
        if (period_f != PERIOD) begin
          bad++;
          $display("FAIL period: got %0d required %0d",
                   period_f, PERIOD);
        end
      end
    end
    total++;
    if (in_data !== 8'h5A) begin
      bad++;
      $display("FAIL raw_5a: got %h required 5a", in_data);
    end
  endtask

  task automatic test_debounce_edges();
    do_reset();
    out_data = 16'h1234;
    dip = 8'h01;
    en = 1'b1;
    frame_step(8'h01, 8'h01);
    frame_step(8'h01, 8'h01);
    frame_step(8'h01, 8'h00);
    frame_step(8'h00, 8'h00);
    frame_step(8'h00, 8'h00);
    frame_step(8'h00, 8'h00);
    total++;
    if (in_data !== 8'h00) begin
      bad++;
      $display("FAIL fall_accept: got %h required 00", in_data);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    dip = 8'h01;
    en = 1'b1;
    frame_step(8'h01, 8'h01);
    frame_step(8'h01, 8'h00);
    frame_step(8'h00, 8'h00);
    frame_step(8'h00, 8'h00);
    frame_step(8'h00, 8'h00);
    total++;
    if (in_data !== 8'h00) begin
      bad++;
      $display("FAIL glitch: got %h required 00", in_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] cur, nxt;
    do_reset();
    cur = 8'($urandom);
    dip = cur;
    out_data = 16'($urandom);
    en = 1'b1;
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 2) == 0) nxt = cur ^ 8'($urandom);
      else nxt = cur;
      frame_step(cur, nxt);
      cur = nxt;
    end
  endtask

  task automatic test_out_change();
    bit ok;
    do_reset();
    out_data = 16'h0000;
    dip = 8'h00;
    en = 1'b1;
    wait_done(ok);
    repeat (40) @(negedge clk);
    out_data = 16'hFFFF;
    wait_done(ok);
    total++;
    if (sdo_f !== 16'h0000 || q595 !== 16'h0000) begin
      bad++;
      $display("FAIL snapshot_old: got %h/%h required 0000",
               sdo_f, q595);
    end
    wait_done(ok);
    total++;
    if (sdo_f !== 16'hFFFF || q595 !== 16'hFFFF) begin
      bad++;
      $display("FAIL snapshot_new: got %h/%h required ffff",
               sdo_f, q595);
    end
  endtask

  task automatic test_en_drop();
    bit ok;
    int r, b;
    logic sp;
    do_reset();
    en = 1'b1;
    wait_done(ok);
    repeat (30) @(negedge clk);
    en = 1'b0;
    wait_done(ok);
    @(negedge clk);
    total++;
    if ({busy, sclk, in_latch} !== 3'b001) begin
      bad++;
      $display("FAIL stop_pins: got %b required 001",
               {busy, sclk, in_latch});
    end
    r = 0;
    b = 0;
    sp = sclk;
    repeat (300) begin
      @(negedge clk);
      if (sclk && !sp) r++;
      if (busy) b++;
      sp = sclk;
    end
    total++;
    if (r != 0 || b != 0) begin
      bad++;
      $display("FAIL stop_quiet: rises %0d busy %0d required 0 0", r, b);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int hi, lowc;
    do_reset();
    dip = 8'hFF;
    en = 1'b1;
    wait_done(ok);
    repeat (30) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (pins() !== RST_PINS) begin
      bad++;
      $display("FAIL async_reset: got %h required %h", pins(), RST_PINS);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    hi = 0;
    for (int i = 0; i < 20 && in_latch; i++) begin
      @(negedge clk);
      if (sclk) hi++;
    end
    lowc = 0;
    while (!in_latch && lowc < 20) begin
      if (sclk) hi++;
      lowc++;
      @(negedge clk);
    end
    total++;
    if (lowc != DIV || hi != 0) begin
      bad++;
      $display("FAIL restart_load: low %0d sclk %0d required %0d 0",
               lowc, hi, DIV);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    en = 1'b0;
    out_data = '0;
    model_reset();
    test_reset();
    test_frame_basic();
    test_debounce_edges();
    test_glitch();
    test_random();
    test_out_change();
    test_en_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_io_engine.md
Name: serial_io_engine

Overview:
- Parametrised shared-clock serial I/O controller for the board's shift-register peripherals.
- Drives one 74HC595-style output chain (LED / seven-segment) and reads one 74HC165-style input chain (DIP) in the same frame, on one serial clock.
- Adds multi-frame debounce and rise/fall edge reporting on inputs, plus a frame-done strobe and free-running/stop control.
- Sits between the top level and the board pins. Replaces separate per-peripheral LED/DIP shift drivers.

Parameters:
- OUT_W, 16, output chain length in bits.
- IN_W, 8, input chain length in bits.
- DIV, 4, serial clock half-period in clk cycles (>=1).
- DEBOUNCE, 3, consecutive frames a changed input must persist before it is accepted (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  run frames back-to-back while high.
- out_data  in  OUT_W  parallel output word, MSB shifted first.
- sclk  out  1  shared serial clock to both chains.
- sdo  out  1  serial data to output chain.
- out_latch  out  1  output chain storage latch (rising edge transfers).
- in_latch  out  1  input chain parallel-load, active low.
- sdi  in  1  serial data from input chain.
- in_data  out  IN_W  debounced input word.
- in_rise  out  IN_W  one-cycle pulse per bit on accepted 0->1.
- in_fall  out  IN_W  one-cycle pulse per bit on accepted 1->0.
- frame_done  out  1  one-cycle pulse at end of each frame.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset values: sclk=0, sdo=0, out_latch=0, in_latch=1, in_data=0, in_rise=0, in_fall=0, frame_done=0, busy=0, state=IDLE, debounce counters=0.
- Reset is asynchronous and takes effect mid-frame. The partial frame is discarded.
- Frame length: N = max(OUT_W, IN_W).
- States and transitions:
  - IDLE: transitions to LOAD on any cycle en=1.
  - LOAD: DIV cycles with in_latch=0. The out_data snapshot is taken on entry. Later out_data changes have no effect until the next frame.
  - SHIFT: N bits, each 2*DIV cycles. sclk is low for the first DIV cycles and high for the second DIV cycles.
  - LATCH: DIV cycles, sclk=0, out_latch=1.
  - DONE: 1 cycle. frame_done=1, debounce results applied. Then goes to LOAD if en=1, else IDLE.
- Frame period is DIV*(2N+2)+1 clk cycles. With defaults this is 137.
- sdo timing: sdo updates on entry to each bit, while sclk is low.
- sdo bit order: the first N-OUT_W bits are 0 (padding), then out_data MSB..LSB. After the last edge, out_data therefore sits aligned in the chain.
- sdi sampling: sdi is sampled in the clk cycle in which sclk goes 0->1, before the edge.
- sdi bit order: the first IN_W samples form raw[IN_W-1:0], MSB first. Later samples are ignored.
- busy=1 from LOAD through DONE.
- en=0 mid-frame: the frame completes normally, including DONE, then the engine goes to IDLE.
- Debounce, per bit i, evaluated in DONE:
  - If raw[i]!=in_data[i], cnt[i]++.
  - If raw[i]==in_data[i], cnt[i]=0.
  - When cnt[i] would reach DEBOUNCE: in_data[i] is updated, cnt[i]=0, and in_rise[i] or in_fall[i] pulses.
  - in_data, in_rise and in_fall change on the cycle after DONE. They are visible together with the next LOAD cycle.
- DEBOUNCE=1 means accepted on the first frame.
- All pulses last exactly one clk.

Decomposition:
- Package serial_io_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, LATCH, DONE);
  - clog2 function;
  - derived constants N_BITS and BIT_CNT_W.
- Sub-module io_debouncer: IN_W-wide, DEBOUNCE-parameterised counter bank with edge outputs. Enabled by the DONE strobe.
- Top FSM, divider and shift registers stay in serial_io_engine.

Test Plan:
- Defaults, en=1, out_data=16'hA5C3, 165 model loaded with 8'h5A:
  - sdo captured on 16 sclk rises equals 1010_0101_1100_0011;
  - out_latch high 4 cycles;
  - frame_done every 137 cycles;
  - raw sample = 8'h5A.
- Input 8'h01 held steady from reset:
  - in_data stays 8'h00 after frames 1 and 2;
  - becomes 8'h01 after frame 3;
  - in_rise=8'h01 for exactly one cycle;
  - in_fall=0 throughout.
- Bit 0 glitches (1 for 2 frames, then back to 0):
  - in_data unchanged;
  - no in_rise/in_fall pulses.
  - Then 8'h00 held 3 frames after acceptance of 8'h01: in_fall=8'h01 once.
- out_data changed from 16'h0000 to 16'hFFFF midway through SHIFT:
  - current frame shifts all zeros;
  - next frame shifts all ones.
- en dropped during SHIFT:
  - frame finishes with frame_done;
  - busy falls;
  - sclk=0, in_latch=1, no further sclk edges.
- reset asserted mid-SHIFT for 3 cycles:
  - outputs take reset values immediately, without waiting for clk;
  - after release with en=1, the first activity is a full 4-cycle LOAD.
